// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one decimal digit per clock, LSD first, start/busy/done handshake.
// Optional macro BCD_INVALID_CHECK_EN adds a registered `invalid` flag for non-BCD operand digits.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout
`ifdef BCD_INVALID_CHECK_EN
    ,
    output logic                invalid
`endif
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t          state;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    shadow;
    logic [CW-1:0]   cnt;
    logic            carry;

    logic [3:0]      a_dig;
    logic [3:0]      b_dig;
    logic [4:0]      raw;
    logic [4:0]      raw_adj;
    logic [3:0]      s_dig;
    logic            c_dig;
    logic [W-1:0]    shadow_next;
    logic            last_digit;

    // Single digit adder; raw is 5 bits so 9+9+1=19 still takes the +6 correction.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        a_dig       = a_q[cnt*4 +: 4];
        b_dig       = b_q[cnt*4 +: 4];
        raw         = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry};
        raw_adj     = raw + 5'd6;
        s_dig       = raw[3:0];
        c_dig       = 1'b0;
        if (raw > 5'd9) begin
            s_dig = raw_adj[3:0];
            c_dig = 1'b1;
        end
        shadow_next = shadow;
        shadow_next[cnt*4 +: 4] = s_dig;
        last_digit  = (cnt == CW'(DIGITS - 1));
    end

`ifdef BCD_INVALID_CHECK_EN
    logic any_invalid;

    always_comb begin
        any_invalid = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a_q[i*4 +: 4] > 4'd9 || b_q[i*4 +: 4] > 4'd9) begin
                any_invalid = 1'b1;
            end
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the shadow result and operand copies are reset too, so an aborted run leaves nothing behind.
            state  <= ST_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            shadow <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef BCD_INVALID_CHECK_EN
            invalid <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    shadow <= shadow_next;
                    carry  <= c_dig;
                    cnt    <= cnt + 1'b1;
                    if (last_digit) begin
                        // sum/cout change only here and hold until the next completion.
                        sum   <= shadow_next;
                        cout  <= c_dig;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
`ifdef BCD_INVALID_CHECK_EN
                        invalid <= any_invalid;
`endif
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (DIGITS=4) using a scoreboard of expected results.
// Define BCD_INVALID_CHECK_EN for both bench and RTL to exercise the invalid flag.
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef BCD_INVALID_CHECK_EN
    logic         invalid;
`endif

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         inv;
    } exp_t;

    exp_t         sb[$];
    int           tests;
    int           fails;
    int           edge_cnt;
    logic [W-1:0] last_sum;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef BCD_INVALID_CHECK_EN
        ,
        .invalid (invalid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Decimal reference: subtract ten on overflow (congruent to +6 mod 16 for non-BCD digits).
    function automatic exp_t bcd_model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t e;
        logic cy;
        int   raw;
        e.sum = '0;
        e.inv = 1'b0;
        cy    = c;
        for (int i = 0; i < DIGITS; i++) begin
            raw = int'(x[i*4 +: 4]) + int'(y[i*4 +: 4]) + int'(cy);
            if (raw >= 10) begin
                raw = raw - 10;
                cy  = 1'b1;
            end else begin
                cy  = 1'b0;
            end
            e.sum[i*4 +: 4] = raw[3:0];
            if (int'(x[i*4 +: 4]) > 9 || int'(y[i*4 +: 4]) > 9) e.inv = 1'b1;
        end
        e.cout = cy;
        return e;
    endfunction

    // Drive one start pulse; returns at the negedge right after the start edge.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        cin   = tc;
        start = 1'b1;
        sb.push_back(bcd_model(ta, tb_v, tc));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for done; lat counts edges after the start edge, -1 on timeout.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!done && lat <= 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        tests++; if (sum !== '0) begin fails++; $display("FAIL reset_sum: got %h expected 0000", sum); end
        tests++; if (cout !== 1'b0) begin fails++; $display("FAIL reset_cout: got %b expected 0", cout); end
`ifdef BCD_INVALID_CHECK_EN
        tests++; if (invalid !== 1'b0) begin fails++; $display("FAIL reset_invalid: got %b expected 0", invalid); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int   lat;
        int   bcnt;
        exp_t e;
        start_op(16'h1234, 16'h5678, 1'b0);
        wait_done(lat, bcnt);
        tests++; if (lat != DIGITS) begin fails++; $display("FAIL basic_latency: got %0d edges expected %0d", lat, DIGITS); end
        tests++; if (bcnt != DIGITS) begin fails++; $display("FAIL basic_busy_cycles: got %0d expected %0d", bcnt, DIGITS); end
        if (lat >= 0) begin
            e = sb.pop_front();
            tests++; if (sum !== e.sum) begin fails++; $display("FAIL basic_sum: got %h expected %h", sum, e.sum); end
            tests++; if (cout !== e.cout) begin fails++; $display("FAIL basic_cout: got %b expected %b", cout, e.cout); end
            last_sum = e.sum;
        end
        @(negedge clk);
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_carry();
        logic [W-1:0] va[4] = '{16'h9999, 16'h9999, 16'h0000, 16'h4721};
        logic [W-1:0] vb[4] = '{16'h0001, 16'h9999, 16'h0000, 16'h5389};
        logic         vc[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int   lat;
        int   bcnt;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            start_op(va[i], vb[i], vc[i]);
            wait_done(lat, bcnt);
            tests++;
            if (lat < 0) begin
                fails++; $display("FAIL carry_timeout_%0d: no done within budget", i);
                sb.delete();
            end else begin
                e = sb.pop_front();
                if (sum !== e.sum || cout !== e.cout) begin
                    fails++;
                    $display("FAIL carry_%0d: got sum=%h cout=%b expected sum=%h cout=%b", i, sum, cout, e.sum, e.cout);
                end
                last_sum = e.sum;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mid_start();
        int   lat;
        int   bcnt;
        int   extra;
        exp_t e;
        start_op(16'h0005, 16'h0004, 1'b0);
        @(negedge clk);
        tests++; if (sum !== last_sum) begin fails++; $display("FAIL mid_sum_hold: got %h expected %h", sum, last_sum); end
        a     = 16'h1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++; if (sum !== last_sum) begin fails++; $display("FAIL mid_sum_hold2: got %h expected %h", sum, last_sum); end
        wait_done(lat, bcnt);
        tests++;
        if (lat < 0) begin
            fails++; $display("FAIL mid_timeout: no done within budget");
            sb.delete();
        end else begin
            e = sb.pop_front();
            if (sum !== e.sum || cout !== e.cout) begin
                fails++; $display("FAIL mid_result: got sum=%h cout=%b expected sum=%h cout=%b", sum, cout, e.sum, e.cout);
            end
            last_sum = e.sum;
        end
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) extra++;
        end
        tests++; if (extra != 0) begin fails++; $display("FAIL mid_extra_done: got %0d extra pulses expected 0", extra); end
    endtask

    task automatic test_reset_mid();
        int   lat;
        int   bcnt;
        exp_t e;
        start_op(16'h1234, 16'h1111, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++; if (sum !== '0) begin fails++; $display("FAIL rstmid_sum: got %h expected 0000", sum); end
        tests++; if (cout !== 1'b0) begin fails++; $display("FAIL rstmid_cout: got %b expected 0", cout); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL rstmid_done: got %b expected 0", done); end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        start_op(16'h0050, 16'h0050, 1'b0);
        wait_done(lat, bcnt);
        tests++;
        if (lat != DIGITS) begin
            fails++; $display("FAIL rstmid_latency: got %0d edges expected %0d", lat, DIGITS);
        end
        if (lat >= 0) begin
            e = sb.pop_front();
            tests++; if (sum !== e.sum || cout !== e.cout) begin
                fails++; $display("FAIL rstmid_result: got sum=%h cout=%b expected sum=%h cout=%b", sum, cout, e.sum, e.cout);
            end
            last_sum = e.sum;
        end else begin
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ops[3] = '{16'h0123, 16'h8765, 16'h9990};
        int   times[3];
        int   cyc;
        exp_t e;
        @(negedge clk);
        a     = ops[0];
        b     = 16'h0877;
        cin   = 1'b0;
        start = 1'b1;
        sb.push_back(bcd_model(ops[0], 16'h0877, 1'b0));
        for (int n = 0; n < 3; n++) begin
            cyc = 0;
            while (!done && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            times[n] = edge_cnt;
            tests++;
            if (!done) begin
                fails++; $display("FAIL b2b_timeout_%0d: no done within budget", n);
                sb.delete();
            end else begin
                e = sb.pop_front();
                if (sum !== e.sum || cout !== e.cout) begin
                    fails++; $display("FAIL b2b_result_%0d: got sum=%h cout=%b expected sum=%h cout=%b", n, sum, cout, e.sum, e.cout);
                end
                last_sum = e.sum;
            end
            if (n < 2) begin
                a = ops[n+1];
                sb.push_back(bcd_model(ops[n+1], 16'h0877, 1'b0));
            end
            @(negedge clk);
        end
        start = 1'b0;
        tests++; if (times[1] - times[0] != DIGITS + 2) begin fails++; $display("FAIL b2b_period_1: got %0d edges expected %0d", times[1] - times[0], DIGITS + 2); end
        tests++; if (times[2] - times[1] != DIGITS + 2) begin fails++; $display("FAIL b2b_period_2: got %0d edges expected %0d", times[2] - times[1], DIGITS + 2); end
        repeat (8) @(negedge clk);
        tests++; if (busy !== 1'b0 || sb.size() != 0) begin fails++; $display("FAIL b2b_idle_after: got busy=%b pending=%0d expected busy=0 pending=0", busy, sb.size()); end
    endtask

    task automatic test_invalid();
`ifdef BCD_INVALID_CHECK_EN
        logic [W-1:0] va[2] = '{16'h00A0, 16'h0010};
        int   lat;
        int   bcnt;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            start_op(va[i], 16'h0000, 1'b0);
            wait_done(lat, bcnt);
            tests++;
            if (lat < 0) begin
                fails++; $display("FAIL invalid_timeout_%0d: no done within budget", i);
                sb.delete();
            end else begin
                e = sb.pop_front();
                if (invalid !== e.inv || sum !== e.sum || cout !== e.cout) begin
                    fails++;
                    $display("FAIL invalid_%0d: got inv=%b sum=%h cout=%b expected inv=%b sum=%h cout=%b",
                             i, invalid, sum, cout, e.inv, e.sum, e.cout);
                end
            end
            @(negedge clk);
        end
`else
        $display("[TB] invalid port not present in this build");
`endif
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        edge_cnt = 0;
        last_sum = '0;
        test_reset();
        test_basic();
        test_carry();
        test_mid_start();
        test_reset_mid();
        test_back_to_back();
        test_invalid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
